// File: rtl/cpu_output_pkg.sv
// Shared definitions for the board-side CPU output controller:
// pacing FSM state encoding and the active-low seven-segment glyph table.
package cpu_output_pkg;

    typedef enum logic [1:0] {
        STEP_WAIT = 2'd0,
        STEP_FIRE = 2'd1,
        RUN       = 2'd2
    } state_t;

    // All segments off (active-low drive).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Hex glyphs ordered {g,f,e,d,c,b,a}, active-low; entry 15 is leftmost.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'b0001110,   // F
        7'b0000110,   // E
        7'b0100001,   // d
        7'b1000110,   // C
        7'b0000011,   // b
        7'b0001000,   // A
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        return HEX_GLYPH[nib];
    endfunction

endpackage

// File: rtl/cpu_output_ctrl_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle strobe on each accepted low-to-high transition.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after it has differed from the old one for
    // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_b;
                press <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_output_ctrl.sv
// Board-side pacing and display controller for the CPU: generates
// cpu_enable from a debounced step button or a run switch, captures the
// CPU output word onto a 4-digit multiplexed seven-segment display and
// mirrors the low PC byte on LEDs.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// STEP_WAIT | single-step mode, waiting for a button press or run_sw=1
// STEP_FIRE | emits the one-cycle cpu_enable for a single step
// RUN       | free-running, cpu_enable every RUN_DIV cycles
module cpu_output_ctrl
    import cpu_output_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SCAN_CYCLES     = 50000,
    parameter int RUN_DIV         = 5000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic [15:0] output_port,
    input  logic [7:0]  pc_low,
    output logic        cpu_enable,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [7:0]  led
);

    localparam int RW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [RW-1:0] RUN_LAST  = RW'(RUN_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

    logic          press;
    logic          run_a;
    logic          run_s;
    state_t        state;
    state_t        state_n;
    logic [RW-1:0] run_cnt;
    logic [RW-1:0] run_cnt_n;
    logic          enable_n;
    logic [15:0]   captured;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [3:0]    nibble;
    logic [6:0]    digit_seg;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (step_btn),
        .press   (press)
    );

    // The mode switch is a slow level, so synchronising it is enough.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_a <= 1'b0;
            run_s <= 1'b0;
        end else begin
            run_a <= run_sw;
            run_s <= run_a;
        end
    end

    // Pacing FSM state, run divider and registered enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= STEP_WAIT;
            run_cnt    <= '0;
            cpu_enable <= 1'b0;
        end else begin
            state      <= state_n;
            run_cnt    <= run_cnt_n;
            cpu_enable <= enable_n;
        end
    end

    // Next state; cpu_enable is computed from the next state so the flop
    // is high exactly during STEP_FIRE and the terminal RUN count.
    always_comb begin
        state_n   = state;
        run_cnt_n = run_cnt;
        case (state)
            STEP_WAIT: begin
                if (run_s) begin
                    state_n   = RUN;
                    run_cnt_n = '0;
                end else if (press) begin
                    state_n = STEP_FIRE;
                end
            end
            STEP_FIRE: begin
                state_n = STEP_WAIT;
            end
            RUN: begin
                if (!run_s) begin
                    state_n   = STEP_WAIT;
                    run_cnt_n = '0;
                end else if (run_cnt == RUN_LAST) begin
                    run_cnt_n = '0;
                end else begin
                    run_cnt_n = run_cnt + 1'b1;
                end
            end
            default: begin
                state_n   = STEP_WAIT;
                run_cnt_n = '0;
            end
        endcase
        enable_n = (state_n == STEP_FIRE) ||
                   ((state_n == RUN) && (run_cnt_n == RUN_LAST));
    end

    // Capture the CPU word only while it is not being advanced; mirror PC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            captured <= '0;
            led      <= '0;
        end else begin
            if (!cpu_enable) begin
                captured <= output_port;
            end
            led <= pc_low;
        end
    end

    // Digit scan timer and digit index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Glyph for the current digit, with optional leading-zero blanking.
    always_comb begin
        nibble    = captured[{idx, 2'b00} +: 4];
        digit_seg = hex_glyph(nibble);
`ifdef LEADING_ZERO_BLANK_EN
        case (idx)
            2'd1:    if (captured[15:4] == 12'h000) digit_seg = SEG_BLANK;
            2'd2:    if (captured[15:8] == 8'h00) digit_seg = SEG_BLANK;
            2'd3:    if (captured[15:12] == 4'h0) digit_seg = SEG_BLANK;
            default: digit_seg = hex_glyph(nibble);
        endcase
`endif
    end

    // Register anode and segments together so a digit never shows a
    // neighbour's glyph.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= digit_seg;
        end
    end

endmodule

// File: tb/tb_cpu_output_ctrl.sv
module tb_cpu_output_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        step_btn;
    logic        run_sw;
    logic [15:0] output_port;
    logic [7:0]  pc_low;
    logic        cpu_enable;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [7:0]  led;

    int checks   = 0;
    int failures = 0;

    int          pulse_q[$];
    logic [10:0] disp_q[$];

    cpu_output_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .SCAN_CYCLES    (2),
        .RUN_DIV        (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .step_btn    (step_btn),
        .run_sw      (run_sw),
        .output_port (output_port),
        .pc_low      (pc_low),
        .cpu_enable  (cpu_enable),
        .seg         (seg),
        .an          (an),
        .led         (led)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    function automatic int an_idx(input logic [3:0] a);
        case (a)
            4'b1101: an_idx = 1;
            4'b1011: an_idx = 2;
            4'b0111: an_idx = 3;
            default: an_idx = 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {an,seg} for the four scan slots of a captured value.
    task automatic push_display(input logic [15:0] v);
        logic [3:0] a;
        logic [6:0] g;
        logic [15:0] hi;
        for (int d = 0; d < 4; d++) begin
            a  = ~(4'b0001 << d);
            g  = glyph(v[4*d +: 4]);
            hi = v >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0 && hi == 16'h0000) g = 7'b1111111;
`endif
            disp_q.push_back({a, g});
        end
    endtask

    task automatic wait_an(input logic [3:0] v);
        for (int i = 0; i < 20 && an !== v; i++) @(negedge clk);
    endtask

    task automatic scan_check(input string tag);
        logic [10:0] e;
        wait_an(4'b0111);
        wait_an(4'b1110);
        for (int d = 0; d < 4; d++) begin
            e = disp_q.pop_front();
            chk(tag, {21'd0, an, seg}, {21'd0, e});
            repeat (2) @(negedge clk);
        end
    endtask

    // Observe cpu_enable for ncyc cycles, matching pulses against pulse_q.
    task automatic watch(input string tag, input int ncyc, input int drop_run_at);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (cpu_enable) begin
                if (pulse_q.size() == 0) chk({tag, "_extra_pulse"}, k, 0);
                else chk({tag, "_pulse_cycle"}, k, pulse_q.pop_front());
            end
            if (k == drop_run_at) run_sw = 1'b0;
        end
        chk({tag, "_missing_pulses"}, pulse_q.size(), 0);
        pulse_q.delete();
    endtask

    initial begin
        int   got;
        logic [15:0] hold_v;

        reset_n     = 1'b0;
        step_btn    = 1'b0;
        run_sw      = 1'b0;
        output_port = 16'h1234;
        pc_low      = 8'h5A;
        hold_v      = 16'hABCD;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cpu_enable", cpu_enable, 0);
        chk("rst_an", an, 4'b1111);
        chk("rst_seg", seg, 7'b1111111);
        chk("rst_led", led, 8'h00);

        // Release: first digit shows "4"
        reset_n = 1'b1;
        for (int i = 0; i < 3 && !(an === 4'b1110 && seg === 7'b0011001); i++)
            @(negedge clk);
        chk("first_digit", {an, seg}, {4'b1110, 7'b0011001});
        chk("led_follow", led, 8'h5A);
        pc_low = 8'hC3;
        @(negedge clk);
        chk("led_update", led, 8'hC3);

        // Bouncy button: no pulse while bouncing
        for (int i = 0; i < 12; i++) begin
            step_btn = ((i % 4) < 2);
            @(negedge clk);
            chk("bounce_no_pulse", cpu_enable, 0);
        end
        // Stable hold: exactly one pulse, 2 sync + 4 debounce + 1 cycles
        step_btn = 1'b1;
        pulse_q.push_back(7);
        watch("step_hold", 20, 0);
        step_btn = 1'b0;
        repeat (10) @(negedge clk);

        // Run mode: pulses every 3 cycles; none after run_sw drops
        output_port = 16'hABCD;
        for (int p = 5; p <= 20; p += 3) pulse_q.push_back(p);
        run_sw = 1'b1;
        watch("run", 32, 20);

        // Display scan order with ABCD
        push_display(16'hABCD);
        scan_check("scan_abcd");

        // Step press after run; change output_port during the pulse
        pulse_q.push_back(7);
        step_btn = 1'b1;
        got = 0;
        for (int k = 1; k <= 12 && got == 0; k++) begin
            @(negedge clk);
            if (cpu_enable) begin
                got = 1;
                chk("capture_pulse_cycle", k, pulse_q.pop_front());
                output_port = 16'h0000;
            end
        end
        chk("capture_pulse_seen", got, 1);
        @(negedge clk);
        chk("pulse_width", cpu_enable, 0);
        chk("hold_glyph", seg, glyph(hold_v[4*an_idx(an) +: 4]));
        repeat (2) @(negedge clk);
        chk("new_value_glyph", seg, 7'b1000000);
        pulse_q.delete();
        step_btn = 1'b0;
        repeat (10) @(negedge clk);

        push_display(16'h0000);
        scan_check("scan_zero");

        // Leading-zero behaviour
        output_port = 16'h0050;
        repeat (3) @(negedge clk);
        push_display(16'h0050);
        scan_check("scan_0050");

        // Async reset while cpu_enable is high in RUN
        run_sw = 1'b1;
        for (int i = 0; i < 12 && cpu_enable !== 1'b1; i++) @(negedge clk);
        chk("run_pulse_before_reset", cpu_enable, 1);
        #1 reset_n = 1'b0;
        #1 chk("async_drop_enable", cpu_enable, 0);
        chk("async_an_off", an, 4'b1111);
        run_sw = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        // Back in STEP_WAIT: nothing until a press, then one pulse
        watch("post_reset_idle", 10, 0);
        pulse_q.push_back(7);
        step_btn = 1'b1;
        watch("post_reset_step", 15, 0);
        step_btn = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
